// File: rtl/fc_mat_feeder_pkg.sv
// Shared types and widths for the FC matrix feeder: AXIS width, lane count, FSM states.
// Default AXIS width applies when DDR_AXIS_DATA_WIDTH is not defined by the build.
`ifndef DDR_AXIS_DATA_WIDTH
`define DDR_AXIS_DATA_WIDTH 64
`endif

package fc_mat_feeder_pkg;

  localparam int FC_DATA_W = `DDR_AXIS_DATA_WIDTH;
  localparam int FC_N      = FC_DATA_W / 8;
  localparam int FC_MAT_W  = FC_N * 9;

  typedef enum logic [1:0] {
    FC_FEED_IDLE  = 2'd0,
    FC_FEED_RUN   = 2'd1,
    FC_FEED_DRAIN = 2'd2
  } fc_feed_state_e;

  // uint8 minus uint8 zero point; the 9-bit signed range -255..255 cannot overflow
  function automatic logic [8:0] fc_zp_diff(input logic [7:0] val, input logic [7:0] zp);
    return {1'b0, val} - {1'b0, zp};
  endfunction

endpackage

// File: rtl/fc_mat_feeder_if.sv
// Bus bundle of the FC feeder: weight AXIS in, X buffer read port, PE array drive.
// master = feeder side, slave = surrounding datapath side.
interface fc_mat_feeder_if
  import fc_mat_feeder_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic [FC_DATA_W-1:0] w_axis_tdata;
  logic                 w_axis_tvalid;
  logic                 w_axis_tready;

  logic                 xbuf_rd_en;
  logic [CNT_W-1:0]     xbuf_rd_addr;
  logic [7:0]           xbuf_rd_data;

  logic [8:0]           mat_x;
  logic [FC_MAT_W-1:0]  mat_w;
  logic                 mat_begin;
  logic                 mat_end;
  logic                 mat_end_last;

  modport master (
    input  w_axis_tdata, w_axis_tvalid, xbuf_rd_data,
    output w_axis_tready, xbuf_rd_en, xbuf_rd_addr,
    output mat_x, mat_w, mat_begin, mat_end, mat_end_last
  );

  modport slave (
    output w_axis_tdata, w_axis_tvalid, xbuf_rd_data,
    input  w_axis_tready, xbuf_rd_en, xbuf_rd_addr,
    input  mat_x, mat_w, mat_begin, mat_end, mat_end_last
  );

endinterface

// File: rtl/fc_zp_sub.sv
// Registered uint8 minus zero point to 9-bit signed; a bubble slot (en low) yields 0.
module fc_zp_sub
  import fc_mat_feeder_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [7:0] val,
  input  logic [7:0] zp,
  output logic [8:0] res
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   res <= '0;
    else if (en) res <= fc_zp_diff(val, zp);
    else         res <= '0;
  end

endmodule

// File: rtl/shift_reg.sv
// Generic fixed-depth delay line with asynchronous active-low clear.
module shift_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/fc_mat_feeder.sv
// FC PE-array front end: streams weight beats, pairs them with X buffer reads, removes zero points.
// Optional FC_FEEDER_STALL_CNT_EN adds stall_cnt / run_cnt performance counters.
//
// state         | meaning
// FC_FEED_IDLE  | waiting for start; config latched on accept
// FC_FEED_RUN   | tready high, one weight beat per handshake, k/g advance
// FC_FEED_DRAIN | last beat taken; wait for it to leave the pipe, then done
module fc_mat_feeder
  import fc_mat_feeder_pkg::*;
#(
  parameter int XBUF_RD_LAT = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_n_x,
  input  logic [CNT_W-1:0] cfg_n_grp,
  input  logic [7:0]       cfg_x_zp,
  input  logic [7:0]       cfg_w_zp,
  output logic             done,
  output logic             busy,
`ifdef FC_FEEDER_STALL_CNT_EN
  output logic [31:0]      stall_cnt,
  output logic [31:0]      run_cnt,
`endif
  fc_mat_feeder_if.master  bus
);

  localparam int               SH_W       = FC_DATA_W + 4;
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [2:0]       DRAIN_LOAD = 3'(XBUF_RD_LAT - 1);

  fc_feed_state_e   state;
  logic [CNT_W-1:0] n_x_q;
  logic [CNT_W-1:0] n_grp_q;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] g;
  logic [7:0]       x_zp_q;
  logic [7:0]       w_zp_q;
  logic             tready_q;
  logic [2:0]       drain_cnt;

  logic             accept;
  logic             k_last;
  logic             g_last;

  assign accept = bus.w_axis_tvalid & tready_q;
  assign k_last = (k == n_x_q - ONE);
  assign g_last = (g == n_grp_q - ONE);

  assign bus.w_axis_tready = tready_q;
  assign bus.xbuf_rd_en    = accept;
  assign bus.xbuf_rd_addr  = k;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= FC_FEED_IDLE;
      n_x_q     <= '0;
      n_grp_q   <= '0;
      x_zp_q    <= '0;
      w_zp_q    <= '0;
      k         <= '0;
      g         <= '0;
      tready_q  <= 1'b0;
      drain_cnt <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        FC_FEED_IDLE: begin
          if (start) begin
            n_x_q   <= cfg_n_x;
            n_grp_q <= cfg_n_grp;
            x_zp_q  <= cfg_x_zp;
            w_zp_q  <= cfg_w_zp;
            k       <= '0;
            g       <= '0;
            if (cfg_n_x == '0 || cfg_n_grp == '0) begin
              done <= 1'b1;
            end else begin
              state    <= FC_FEED_RUN;
              tready_q <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        FC_FEED_RUN: begin
          if (accept) begin
            if (k_last) begin
              k <= '0;
              if (g_last) begin
                state     <= FC_FEED_DRAIN;
                tready_q  <= 1'b0;
                drain_cnt <= DRAIN_LOAD;
              end else begin
                g <= g + ONE;
              end
            end else begin
              k <= k + ONE;
            end
          end
        end
        FC_FEED_DRAIN: begin
          // terminal count lands done on the same cycle the last beat reaches mat_*
          if (drain_cnt == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FC_FEED_IDLE;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        default: state <= FC_FEED_IDLE;
      endcase
    end
  end

  logic [SH_W-1:0]      sh_d;
  logic [SH_W-1:0]      sh_q;
  logic                 dly_valid;
  logic                 dly_begin;
  logic                 dly_end;
  logic                 dly_last;
  logic [FC_DATA_W-1:0] dly_tdata;

  // flags are qualified by accept so a bubble slot can never carry a tag
  assign sh_d = {accept,
                 accept & (k == '0),
                 accept & k_last,
                 accept & k_last & g_last,
                 bus.w_axis_tdata};

  shift_reg #(
    .WIDTH (SH_W),
    .DEPTH (XBUF_RD_LAT)
  ) u_align (
    .clk  (clk),
    .rstn (rstn),
    .d    (sh_d),
    .q    (sh_q)
  );

  assign {dly_valid, dly_begin, dly_end, dly_last, dly_tdata} = sh_q;

  logic [8:0]          mat_x_q;
  logic [FC_MAT_W-1:0] mat_w_q;
  logic                begin_q;
  logic                end_q;
  logic                last_q;

  fc_zp_sub u_x_sub (
    .clk  (clk),
    .rstn (rstn),
    .en   (dly_valid),
    .val  (bus.xbuf_rd_data),
    .zp   (x_zp_q),
    .res  (mat_x_q)
  );

  for (genvar i = 0; i < FC_N; i++) begin : g_lane
    fc_zp_sub u_w_sub (
      .clk  (clk),
      .rstn (rstn),
      .en   (dly_valid),
      .val  (dly_tdata[8*i +: 8]),
      .zp   (w_zp_q),
      .res  (mat_w_q[9*i +: 9])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      begin_q <= 1'b0;
      end_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      begin_q <= dly_begin;
      end_q   <= dly_end;
      last_q  <= dly_last;
    end
  end

  assign bus.mat_x        = mat_x_q;
  assign bus.mat_w        = mat_w_q;
  assign bus.mat_begin    = begin_q;
  assign bus.mat_end      = end_q;
  assign bus.mat_end_last = last_q;

`ifdef FC_FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
      run_cnt   <= '0;
    end else if (state == FC_FEED_IDLE) begin
      if (start) begin
        stall_cnt <= '0;
        run_cnt   <= '0;
      end
    end else begin
      run_cnt <= run_cnt + 32'd1;
      if (state == FC_FEED_RUN && !bus.w_axis_tvalid) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fc_mat_feeder.sv
// Bench for fc_mat_feeder: table of runs checked through a cycle-stamped scoreboard,
// plus hand sequences for the degenerate start and a mid-run reset.
module tb_fc_mat_feeder;
  import fc_mat_feeder_pkg::*;

  localparam int CNT_W = 16;
  localparam int LAT   = 2;

  typedef struct {
    int         n_x;
    int         n_grp;
    logic [7:0] x_zp;
    logic [7:0] w_zp;
    logic [15:0] mask;
    bit         fixed;
    logic [7:0] x_fix;
    logic [7:0] w_fix;
    logic [8:0] exp_x;
    logic [8:0] exp_w0;
  } case_t;

  typedef struct {
    int                  cyc;
    logic [8:0]          x;
    logic [FC_MAT_W-1:0] w;
    logic                b_f;
    logic                e_f;
    logic                l_f;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [CNT_W-1:0] cfg_n_x;
  logic [CNT_W-1:0] cfg_n_grp;
  logic [7:0]       cfg_x_zp;
  logic [7:0]       cfg_w_zp;
  logic             done;
  logic             busy;
`ifdef FC_FEEDER_STALL_CNT_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      run_cnt;
`endif

  fc_mat_feeder_if #(.CNT_W(CNT_W)) bus ();

  fc_mat_feeder #(
    .XBUF_RD_LAT (LAT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .cfg_n_x   (cfg_n_x),
    .cfg_n_grp (cfg_n_grp),
    .cfg_x_zp  (cfg_x_zp),
    .cfg_w_zp  (cfg_w_zp),
    .done      (done),
    .busy      (busy),
`ifdef FC_FEEDER_STALL_CNT_EN
    .stall_cnt (stall_cnt),
    .run_cnt   (run_cnt),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  // X buffer model: sampled mid-cycle, so LAT+1 negedge stages give LAT posedge latency
  logic [7:0] mem [256];
  logic [7:0] xb_pipe [LAT+1];
  always @(negedge clk) begin
    xb_pipe[0] <= bus.xbuf_rd_en ? mem[bus.xbuf_rd_addr[7:0]] : 8'hA5;
    for (int i = 1; i <= LAT; i++) xb_pipe[i] <= xb_pipe[i-1];
  end
  assign bus.xbuf_rd_data = xb_pipe[LAT];

  exp_t       sb [$];
  exp_t       ev;
  exp_t       pv;
  int         k_m, g_m, run_nx, run_ng;
  logic [7:0] run_xzp, run_wzp;
  int         beats_seen, end_last_seen, done_seen, done_cyc, last_acc, acc_total;
  logic [8:0] last_x, last_w0;

  always @(negedge clk) begin
    if (rstn) begin
      if (sb.size() > 0 && sb[0].cyc + LAT + 1 < cyc) begin
        ev = sb.pop_front();
        chk("beat_latency", 128'(cyc), 128'(ev.cyc + LAT + 1));
      end
      if (sb.size() > 0 && sb[0].cyc + LAT + 1 == cyc) begin
        ev = sb.pop_front();
        chk("beat", {bus.mat_x, bus.mat_w, bus.mat_begin, bus.mat_end, bus.mat_end_last},
            {ev.x, ev.w, ev.b_f, ev.e_f, ev.l_f});
        beats_seen++;
        last_x  = bus.mat_x;
        last_w0 = bus.mat_w[8:0];
        if (bus.mat_end_last) end_last_seen++;
      end else begin
        chk("bubble", {bus.mat_x, bus.mat_w, bus.mat_begin, bus.mat_end, bus.mat_end_last}, '0);
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
      if (bus.w_axis_tvalid && bus.w_axis_tready) begin
        chk("rd_port", {bus.xbuf_rd_en, bus.xbuf_rd_addr}, {1'b1, 16'(k_m)});
        pv.cyc = cyc;
        pv.x   = 9'({1'b0, mem[k_m]}) - 9'({1'b0, run_xzp});
        for (int i = 0; i < FC_N; i++)
          pv.w[9*i +: 9] = 9'({1'b0, bus.w_axis_tdata[8*i +: 8]}) - 9'({1'b0, run_wzp});
        pv.b_f = (k_m == 0);
        pv.e_f = (k_m == run_nx - 1);
        pv.l_f = pv.e_f && (g_m == run_ng - 1);
        sb.push_back(pv);
        acc_total++;
        last_acc = cyc;
        if (k_m == run_nx - 1) begin
          k_m = 0;
          g_m++;
        end else begin
          k_m++;
        end
      end
    end
  end

  function automatic logic [FC_DATA_W-1:0] rand_tdata();
    logic [FC_DATA_W-1:0] v;
    for (int i = 0; i < FC_N; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic model_init(input int nx, input int ng, input logic [7:0] xzp, input logic [7:0] wzp);
    k_m = 0; g_m = 0; run_nx = nx; run_ng = ng; run_xzp = xzp; run_wzp = wzp;
    beats_seen = 0; end_last_seen = 0; done_seen = 0;
  endtask

  task automatic run_case(input string nm, input case_t c);
    bit got_done;
    if (c.fixed) mem[0] = c.x_fix;
    model_init(c.n_x, c.n_grp, c.x_zp, c.w_zp);
    @(posedge clk); #1;
    cfg_n_x = 16'(c.n_x); cfg_n_grp = 16'(c.n_grp);
    cfg_x_zp = c.x_zp; cfg_w_zp = c.w_zp;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_n_x = 16'd1; cfg_n_grp = 16'd1; cfg_x_zp = 8'h5A; cfg_w_zp = 8'hC3;
    chk({nm, "_busy_on"}, 128'(busy), 128'(1));
    got_done = 1'b0;
    for (int slot = 0; slot < 300 && !got_done; slot++) begin
      bus.w_axis_tvalid = (slot < 16) ? !c.mask[slot] : 1'b1;
      bus.w_axis_tdata  = c.fixed ? {FC_N{c.w_fix}} : rand_tdata();
      start = (slot == 2);
      @(posedge clk); #1;
      got_done = (done_seen > 0);
    end
    start = 1'b0;
    bus.w_axis_tvalid = 1'b0;
    chk({nm, "_done_seen"}, 128'(got_done), 128'(1));
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_beats"}, 128'(beats_seen), 128'(c.n_x * c.n_grp));
    chk({nm, "_sb_empty"}, 128'(sb.size()), 128'(0));
    chk({nm, "_done_lat"}, 128'(done_cyc - last_acc), 128'(LAT + 1));
    chk({nm, "_end_last_cnt"}, 128'(end_last_seen), 128'(1));
    chk({nm, "_done_once"}, 128'(done_seen), 128'(1));
    chk({nm, "_busy_off"}, 128'(busy), 128'(0));
    if (c.fixed) begin
      chk({nm, "_x_value"}, 128'(last_x), 128'(c.exp_x));
      chk({nm, "_w0_value"}, 128'(last_w0), 128'(c.exp_w0));
    end
  endtask

  case_t cases [5];

  initial begin
    cases[0] = '{n_x: 4, n_grp: 2, x_zp: 8'h00, w_zp: 8'h00, mask: 16'h0000, fixed: 1'b0,
                 x_fix: 8'h00, w_fix: 8'h00, exp_x: 9'h000, exp_w0: 9'h000};
    cases[1] = '{n_x: 1, n_grp: 1, x_zp: 8'hFF, w_zp: 8'h00, mask: 16'h0000, fixed: 1'b1,
                 x_fix: 8'h00, w_fix: 8'hFF, exp_x: 9'h101, exp_w0: 9'h0FF};
    cases[2] = '{n_x: 3, n_grp: 1, x_zp: 8'h20, w_zp: 8'h40, mask: 16'h0006, fixed: 1'b0,
                 x_fix: 8'h00, w_fix: 8'h00, exp_x: 9'h000, exp_w0: 9'h000};
    cases[3] = '{n_x: 1, n_grp: 3, x_zp: 8'h10, w_zp: 8'h80, mask: 16'h0000, fixed: 1'b0,
                 x_fix: 8'h00, w_fix: 8'h00, exp_x: 9'h000, exp_w0: 9'h000};
    cases[4] = '{n_x: 5, n_grp: 2, x_zp: 8'h80, w_zp: 8'h7F, mask: 16'hA492, fixed: 1'b0,
                 x_fix: 8'h00, w_fix: 8'h00, exp_x: 9'h000, exp_w0: 9'h000};

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i <= LAT; i++) xb_pipe[i] = 8'h00;
    model_init(1, 1, 8'h00, 8'h00);
    acc_total = 0; done_cyc = 0; last_acc = 0;
    rstn = 1'b0; start = 1'b0;
    cfg_n_x = '0; cfg_n_grp = '0; cfg_x_zp = '0; cfg_w_zp = '0;
    bus.w_axis_tvalid = 1'b0; bus.w_axis_tdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_mat", {bus.mat_x, bus.mat_w, bus.mat_begin, bus.mat_end, bus.mat_end_last}, '0);
    chk("reset_ctrl", {done, busy, bus.w_axis_tready, bus.xbuf_rd_en, bus.xbuf_rd_addr}, '0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_case($sformatf("case%0d", i), cases[i]);

    // degenerate start: zero groups
    model_init(4, 0, 8'h00, 8'h00);
    bus.w_axis_tvalid = 1'b1;
    bus.w_axis_tdata  = rand_tdata();
    cfg_n_x = 16'd4; cfg_n_grp = 16'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("degen_done", {done, busy, bus.w_axis_tready}, {1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("degen_after", {done, busy, bus.w_axis_tready}, '0);
    repeat (4) @(posedge clk);
    #1;
    chk("degen_no_beats", 128'(acc_total - 0 >= 0 ? beats_seen : -1), 128'(0));
    bus.w_axis_tvalid = 1'b0;

    // reset after five accepted beats
    begin
      int base;
      model_init(4, 4, 8'h11, 8'h22);
      cfg_n_x = 16'd4; cfg_n_grp = 16'd4; cfg_x_zp = 8'h11; cfg_w_zp = 8'h22;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      base = acc_total;
      bus.w_axis_tvalid = 1'b1;
      for (int i = 0; i < 50 && acc_total - base < 5; i++) begin
        bus.w_axis_tdata = rand_tdata();
        @(posedge clk); #1;
      end
      chk("rst_accepts", 128'(acc_total - base), 128'(5));
      rstn = 1'b0;
      bus.w_axis_tvalid = 1'b0;
      sb.delete();
      #1;
      chk("rst_mat", {bus.mat_x, bus.mat_w, bus.mat_begin, bus.mat_end, bus.mat_end_last}, '0);
      chk("rst_ctrl", {done, busy, bus.w_axis_tready, bus.xbuf_rd_en, bus.xbuf_rd_addr}, '0);
      @(posedge clk); #1;
      rstn = 1'b1;
      done_seen = 0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_no_done", 128'(done_seen), 128'(0));
    end

    run_case("after_rst", cases[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_mat_feeder.md
Name: fc_mat_feeder

Overview:
- Front end of the FC PE array. Streams one weight beat per cycle from the DDR weight AXIS and broadcasts the matching input activation read from the X buffer.
- Applies zero-point subtraction to both operands, then drives mat_x, mat_w, mat_begin, mat_end and mat_end_last.
- The PE array has no stall input. Whenever no beat is available, the feeder inserts zero-valued bubble cycles (x=0, w=0, flags low). These add 0 to every accumulator.

Parameters:
- XBUF_RD_LAT, 2, X buffer read latency in cycles (1..4).
- CNT_W, 16, width of the K and group counters.

Ports:
- clk  in  1  single clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- cfg_n_x  in  CNT_W  input vector length K
- cfg_n_grp  in  CNT_W  number of N-lane output groups, ceil(OC/N)
- cfg_x_zp  in  8  activation zero point (uint8)
- cfg_w_zp  in  8  weight zero point (uint8)
- done  out  1  one-cycle pulse after the last beat leaves the pipe
- busy  out  1  high from start accept to done
- xbuf_rd_en  out  1  X buffer read enable
- xbuf_rd_addr  out  CNT_W  X buffer read address (= k)
- xbuf_rd_data  in  8  uint8 activation, valid XBUF_RD_LAT cycles after rd_en
- w_axis_tdata  in  `DDR_AXIS_DATA_WIDTH  N uint8 weights; lane i in bits [8i+:8]
- w_axis_tvalid  in  1
- w_axis_tready  out  1
- mat_x  out  9  signed activation
- mat_w  out  N*9  signed weights; lane i in bits [9i+:9]
- mat_begin  out  1
- mat_end  out  1
- mat_end_last  out  1

Behaviour:
- N = `DDR_AXIS_DATA_WIDTH/8.
- Reset values: all outputs 0; state IDLE; counters 0; pipeline flags 0.
- Configuration is latched on start acceptance. cfg inputs are don't-care afterwards.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE, start with n_x==0 or n_grp==0: go to IDLE, done=1 on the next cycle, no handshakes.
  - IDLE, start otherwise: go to RUN, k=0, g=0.
  - RUN: w_axis_tready=1. A beat is accepted when tvalid&&tready.
  - RUN, accepting the beat with k==n_x-1 and g==n_grp-1: go to DRAIN, tready drops the next cycle.
  - DRAIN: wait XBUF_RD_LAT+1 cycles, pulse done, go to IDLE.
- start is ignored while busy.
- Per accepted beat:
  - xbuf_rd_en=1 and xbuf_rd_addr=k, combinational with the handshake.
  - Tag flags: begin=(k==0), end=(k==n_x-1), last=end&&(g==n_grp-1).
  - Advance k. When k wraps from n_x-1 to 0, advance g.
- Alignment:
  - tdata, flags and a valid bit are delayed XBUF_RD_LAT cycles to align with xbuf_rd_data.
  - A final register stage computes mat_x={1'b0,x}-{1'b0,x_zp} and mat_w[i]={1'b0,w_i}-{1'b0,w_zp} as 9-bit signed. The range -255..255 cannot overflow.
- Latency: accepted beat to mat_* outputs is exactly XBUF_RD_LAT+1 cycles.
- Bubbles: a slot with no accepted beat (tvalid low) outputs mat_x=0, mat_w=0, flags 0. Bubbles may fall anywhere, including between begin and end of a group.
- mat_begin and mat_end are both 1 on the same beat when n_x==1.
- Reset mid-operation: the whole pipe is cleared immediately. No done pulse, no partial flags emitted.

Optional Feature:
- Macro: FC_FEEDER_STALL_CNT_EN.
- With it defined, two extra outputs:
  - stall_cnt (32 bit): counts RUN cycles with tvalid low.
  - run_cnt (32 bit): counts RUN+DRAIN cycles.
  - Both clear on start acceptance and hold after done.
- Without it: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared include (incl.vh):
  - `DDR_AXIS_DATA_WIDTH.
  - FC lane count N.
  - FSM state encodings FC_FEED_IDLE, FC_FEED_RUN, FC_FEED_DRAIN.
- Alignment delay reuses the existing shift_reg for tdata, flags and valid.
- One natural sub-module: fc_zp_sub, a per-lane registered uint8-minus-zero-point to 9-bit signed converter. It is instantiated N+1 times.

Test Plan:
- Basic run (n_x=4, n_grp=2, zp=0, tvalid always 1, XBUF_RD_LAT=2):
  - 8 beats, mat_x matches xbuf[0..3] twice.
  - mat_begin at output cycles 0 and 4; mat_end at cycles 3 and 7; mat_end_last only at cycle 7.
  - First output 3 cycles after the first accept; done 3 cycles after the last accept.
- Zero points (x=0x00, x_zp=0xFF, w lane=0xFF, w_zp=0x00): mat_x=-255 (9'h101), mat_w lane=+255 (9'h0FF).
- Bubbles (n_x=3, tvalid low for 2 cycles after the first beat): a 2-cycle zero gap between the begin beat and the next beat; no flags in the gap; total beats=3.
- n_x=1, n_grp=3: every output beat has mat_begin=mat_end=1; mat_end_last only on beat 3.
- Degenerate (start with n_grp=0): tready stays 0, done pulses the next cycle, no mat_* activity.
- Mid-run reset (rstn low for 1 cycle after 5 accepted beats): all outputs 0 at once, state IDLE; a new start then runs cleanly from k=0.
